mc_run_ctrl: RTL and testbench



---
 rtl/mc_run_ctrl_if.sv | 18 +
 rtl/mc_run_ctrl.sv | 119 +++++++++++
 tb/tb_mc_run_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_run_ctrl_if.sv
// mc_run_ctrl_if: program-load channel between a host/loader and mc_run_ctrl.
//   load_valid  host presents a program word
//   load_ready  controller accepts a word (only while idle)
//   load_addr   target instruction address
//   load_data   instruction word
// master = host/loader side, slave = controller side.
interface mc_run_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
);
    logic              load_valid;
    logic              load_ready;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;

    modport master (output load_valid, load_addr, load_data, input load_ready);
    modport slave  (input load_valid, load_addr, load_data, output load_ready);
endinterface

// File: rtl/mc_run_ctrl.sv
// mc_run_ctrl: program-load and run controller for the multicycle core.
// Streams program words into instruction memory, arms the core with a start
// PC, enables it and counts cycles until the core halts or the cycle budget
// runs out, then reports the result and waits for the host to drop run_req.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ld (slave)          load_valid/load_ready/load_addr/load_data channel
//   run_req, start_pc   level run request and PC captured on acceptance
//   imem_we/waddr/wdata registered instruction-memory write port
//   core_pc_nu, core_en initial PC and clock enable to the core
//   core_halt           halt from the core, only looked at while running
//   done, timeout       run finished / finished by budget expiry
//   cycle_cnt           cycles spent running
module mc_run_ctrl #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 15,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 170
) (
    input  logic              clk,
    input  logic              rst,
    mc_run_ctrl_if.slave      ld,
    input  logic              run_req,
    input  logic [DATA_W-1:0] start_pc,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic [DATA_W-1:0] core_pc_nu,
    output logic              core_en,
    input  logic              core_halt,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CYCLES - 1);

    state_t            state, state_nxt;
    logic              ready_q;
    logic              accept;
    logic              budget_hit;
    logic [DATA_W-1:0] pc_cap;

    assign ld.load_ready = ready_q;
    assign accept        = ld.load_valid & ready_q;
    assign budget_hit    = (cycle_cnt == LAST_CNT);

    // A beat accepted in the same idle cycle as run_req wins; the run request
    // is simply looked at again on the following cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (run_req && !accept) state_nxt = S_ARM;
            S_ARM:   state_nxt = S_RUN;
            S_RUN:   if (core_halt || budget_hit) state_nxt = S_DONE;
            S_DONE:  if (!run_req) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ready_q    <= 1'b0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
            pc_cap     <= '0;
            core_pc_nu <= '0;
            core_en    <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            cycle_cnt  <= '0;
        end else begin
            state   <= state_nxt;
            // Ready and enable are registered from the next state so they are
            // glitch-free and line up exactly with the IDLE / RUN cycles.
            ready_q <= (state_nxt == S_IDLE);
            core_en <= (state_nxt == S_RUN);

            imem_we <= accept;
            if (accept) begin
                imem_waddr <= ld.load_addr;
                imem_wdata <= ld.load_data;
            end

            unique case (state)
                S_IDLE: begin
                    if (state_nxt == S_ARM) pc_cap <= start_pc;
                end
                S_ARM: begin
                    core_pc_nu <= pc_cap;
                    cycle_cnt  <= '0;
                    done       <= 1'b0;
                    timeout    <= 1'b0;
                end
                S_RUN: begin
                    // The halting / expiring cycle is counted too.
                    cycle_cnt <= cycle_cnt + 1'b1;
                    if (core_halt) begin
                        done    <= 1'b1;
                        timeout <= 1'b0;
                    end else if (budget_hit) begin
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end
                end
                S_DONE: begin
                    // timeout and cycle_cnt stay visible until the next arm.
                    if (!run_req) done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_run_ctrl.sv
// Self-checking bench for mc_run_ctrl: randomized loads and runs checked
// against expectations derived from the load/run rules.
module tb_mc_run_ctrl;
    localparam int DATA_W     = 16;
    localparam int ADDR_W     = 15;
    localparam int CNT_W      = 16;
    localparam int MAX_CYCLES = 170;

    logic              clk = 1'b0;
    logic              rst;
    logic              run_req;
    logic [DATA_W-1:0] start_pc;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [DATA_W-1:0] imem_wdata;
    logic [DATA_W-1:0] core_pc_nu;
    logic              core_en;
    logic              core_halt;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_cnt;

    mc_run_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ld ();

    mc_run_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .MAX_CYCLES(MAX_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .ld(ld),
        .run_req(run_req), .start_pc(start_pc),
        .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
        .core_pc_nu(core_pc_nu), .core_en(core_en), .core_halt(core_halt),
        .done(done), .timeout(timeout), .cycle_cnt(cycle_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic exp_ready;   // model: controller should be accepting beats this cycle

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock. A beat offered while the model says "ready" (and not
    // in reset) must show up as a one-cycle write right after the edge.
    task automatic tick();
        logic              acc;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        acc = ld.load_valid && exp_ready && !rst;
        a   = ld.load_addr;
        d   = ld.load_data;
        @(posedge clk);
        #1;
        chk("imem_we", 32'(imem_we), 32'(acc));
        if (acc) begin
            chk("imem_waddr", 32'(imem_waddr), 32'(a));
            chk("imem_wdata", 32'(imem_wdata), 32'(d));
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_load_ready", 32'(ld.load_ready), 32'd0);
        chk("rst_imem_we",    32'(imem_we),       32'd0);
        chk("rst_imem_waddr", 32'(imem_waddr),    32'd0);
        chk("rst_imem_wdata", 32'(imem_wdata),    32'd0);
        chk("rst_core_pc_nu", 32'(core_pc_nu),    32'd0);
        chk("rst_core_en",    32'(core_en),       32'd0);
        chk("rst_done",       32'(done),          32'd0);
        chk("rst_timeout",    32'(timeout),       32'd0);
        chk("rst_cycle_cnt",  32'(cycle_cnt),     32'd0);
    endtask

    task automatic rand_beat(input bit valid);
        ld.load_valid = valid;
        ld.load_addr  = ADDR_W'($urandom);
        ld.load_data  = DATA_W'($urandom);
    endtask

    // Reset with a beat offered on the reset edge: that write must be dropped.
    task automatic do_reset(input int cycles);
        rst     = 1'b1;
        run_req = 1'b0;
        rand_beat(1'b1);
        tick();
        ld.load_valid = 1'b0;
        repeat (cycles - 1) tick();
        check_reset_vals();
        rst       = 1'b0;
        exp_ready = 1'b0;
        tick();
        exp_ready = 1'b1;
        chk("ready_after_rst", 32'(ld.load_ready), 32'd1);
    endtask

    task automatic load_burst(input int beats, input bit gaps);
        for (int i = 0; i < beats; i++) begin
            chk("load_ready", 32'(ld.load_ready), 32'd1);
            rand_beat(gaps ? 1'($urandom_range(0, 1)) : 1'b1);
            tick();
        end
        ld.load_valid = 1'b0;
        tick();
    endtask

    // IDLE -> ARM -> first RUN cycle. With collide, a beat is offered in the
    // same cycle as run_req and must delay the arm by one cycle.
    task automatic start_run(input logic [DATA_W-1:0] pc, input bit collide);
        run_req  = 1'b1;
        start_pc = pc;
        if (collide) begin
            rand_beat(1'b1);
            tick();
            ld.load_valid = 1'b0;
            chk("collide_ready", 32'(ld.load_ready), 32'd1);
            chk("collide_en",    32'(core_en),       32'd0);
        end
        tick();
        exp_ready = 1'b0;
        start_pc  = DATA_W'($urandom);   // must not leak into core_pc_nu
        chk("arm_ready", 32'(ld.load_ready), 32'd0);
        chk("arm_en",    32'(core_en),       32'd0);
        tick();
        chk("run_pc",      32'(core_pc_nu), 32'(pc));
        chk("run_cnt0",    32'(cycle_cnt),  32'd0);
        chk("run_done0",   32'(done),       32'd0);
        chk("run_timeout0",32'(timeout),    32'd0);
    endtask

    // halt_at: RUN cycle number on which core_halt is raised (0 = never).
    task automatic run(input logic [DATA_W-1:0] pc, input int halt_at, input bit collide);
        int n;
        int exp_len;
        bit exp_to;
        bit halts;
        halts   = (halt_at > 0) && (halt_at <= MAX_CYCLES);
        exp_len = halts ? halt_at : MAX_CYCLES;
        exp_to  = !halts;
        start_run(pc, collide);
        n = 0;
        while (core_en === 1'b1 && n < MAX_CYCLES + 5) begin
            n++;
            core_halt = (n == halt_at);
            run_req   = 1'($urandom_range(0, 1));   // ignored while running
            rand_beat(1'($urandom_range(0, 1)));    // never accepted while running
            tick();
        end
        core_halt     = 1'b0;
        ld.load_valid = 1'b0;
        run_req       = 1'b1;
        chk("en_cycles",  32'(n),         32'(exp_len));
        chk("done_set",   32'(done),      32'd1);
        chk("timeout",    32'(timeout),   32'(exp_to));
        chk("cycle_cnt",  32'(cycle_cnt), 32'(exp_len));
        chk("done_en",    32'(core_en),   32'd0);
        repeat ($urandom_range(1, 5)) begin
            core_halt = 1'($urandom_range(0, 1));   // ignored outside RUN
            tick();
            chk("hold_done",    32'(done),         32'd1);
            chk("hold_timeout", 32'(timeout),      32'(exp_to));
            chk("hold_cnt",     32'(cycle_cnt),    32'(exp_len));
            chk("hold_en",      32'(core_en),      32'd0);
            chk("hold_ready",   32'(ld.load_ready),32'd0);
        end
        core_halt = 1'b0;
        run_req   = 1'b0;
        tick();
        exp_ready = 1'b1;
        chk("ack_done",    32'(done),          32'd0);
        chk("ack_ready",   32'(ld.load_ready), 32'd1);
        chk("ack_cnt",     32'(cycle_cnt),     32'(exp_len));
        chk("ack_timeout", 32'(timeout),       32'(exp_to));
        core_halt = 1'b1;
        tick();
        core_halt = 1'b0;
        chk("idle_halt_en",   32'(core_en), 32'd0);
        chk("idle_halt_done", 32'(done),    32'd0);
    endtask

    // Reset lands on RUN cycle at_cycle; everything must clear on that edge.
    task automatic run_reset(input logic [DATA_W-1:0] pc, input int at_cycle);
        start_run(pc, 1'b0);
        for (int k = 1; k < at_cycle; k++) tick();
        chk("pre_rst_en", 32'(core_en), 32'd1);
        run_req = 1'b0;
        rst     = 1'b1;
        rand_beat(1'b1);
        tick();
        ld.load_valid = 1'b0;
        check_reset_vals();
        rst = 1'b0;
        tick();
        exp_ready = 1'b1;
        chk("ready_after_run_rst", 32'(ld.load_ready), 32'd1);
    endtask

    initial begin
        logic [ADDR_W-1:0] b_addr [3];
        logic [DATA_W-1:0] b_data [3];
        b_addr = '{15'd0, 15'd1, 15'd2};
        b_data = '{16'h880A, 16'h891A, 16'h999A};
        rst = 1'b1; run_req = 1'b0; start_pc = '0; core_halt = 1'b0;
        ld.load_valid = 1'b0; ld.load_addr = '0; ld.load_data = '0;
        exp_ready = 1'b0;

        do_reset(2);

        for (int i = 0; i < 3; i++) begin
            chk("burst_ready", 32'(ld.load_ready), 32'd1);
            ld.load_valid = 1'b1;
            ld.load_addr  = b_addr[i];
            ld.load_data  = b_data[i];
            tick();
        end
        ld.load_valid = 1'b0;
        tick();
        load_burst(12, 1'b1);

        run(16'h0000, 40, 1'b0);
        run(DATA_W'($urandom), 0, 1'b0);
        run(DATA_W'($urandom), MAX_CYCLES, 1'b0);
        run(DATA_W'($urandom), 1, 1'b1);
        for (int r = 0; r < 5; r++) begin
            load_burst(int'($urandom_range(0, 6)), 1'b1);
            run(DATA_W'($urandom), int'($urandom_range(1, 200)), 1'($urandom_range(0, 1)));
        end

        run_reset(16'h02D1, 25);
        load_burst(6, 1'b0);
        do_reset(3);
        run(DATA_W'($urandom), MAX_CYCLES - 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
